// File: rtl/vect_add_arbiter.sv
// -----------------------------------------------------------------------------
// vect_add_arbiter
//   Shares one combinational vect_adder between two requesters (r0, r1).
//   A round-robin arbiter picks one requester per cycle and drives its
//   operands onto the shared adder. The lane-wise sum is captured in a
//   one-entry output register and returned over a valid/ready stream that is
//   tagged with the id of the requester that produced it.
//
//   Parameters
//     WIDTH  bits per lane; must match the attached vect_adder
//     FRAC   fractional bits per lane; carried for documentation only, the
//            sum is plain two's-complement addition
//     Lane count is the global `N_MAX; vector buses are `N_MAX*WIDTH bits.
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     r0_valid/r0_ready     requester 0 handshake, r0_a/r0_b operands
//     r1_valid/r1_ready     requester 1 handshake, r1_a/r1_b operands
//     add_a/add_b           operands to the shared adder (zero when idle)
//     add_sum               combinational sum returned by the shared adder
//     out_valid/out_ready   result stream handshake
//     out_vect/out_src      registered sum and id of its requester
// -----------------------------------------------------------------------------
`ifndef N_MAX
`define N_MAX 2
`endif

module vect_add_arbiter #(
  parameter int WIDTH = 43,
  parameter int FRAC  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      r0_valid,
  output logic                      r0_ready,
  input  logic [`N_MAX*WIDTH-1:0]   r0_a,
  input  logic [`N_MAX*WIDTH-1:0]   r0_b,
  input  logic                      r1_valid,
  output logic                      r1_ready,
  input  logic [`N_MAX*WIDTH-1:0]   r1_a,
  input  logic [`N_MAX*WIDTH-1:0]   r1_b,
  output logic [`N_MAX*WIDTH-1:0]   add_a,
  output logic [`N_MAX*WIDTH-1:0]   add_b,
  input  logic [`N_MAX*WIDTH-1:0]   add_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [`N_MAX*WIDTH-1:0]   out_vect,
  output logic                      out_src
);

  localparam int VW = `N_MAX * WIDTH;

  // Fixed-point format sanity: the fraction cannot be wider than the lane.
  if (FRAC > WIDTH) begin : g_frac_check
    $error("vect_add_arbiter: FRAC must not exceed WIDTH");
  end

  // The output register is either empty or holding one result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   vect_q,  vect_d;
  logic            src_q,   src_d;
  logic            prio_q,  prio_d;

  logic            can_accept;
  logic            gnt_vld;
  logic            gnt_id;

  // A slot is free when the register is empty or is being drained this cycle,
  // which allows one result per cycle while out_ready stays high.
  assign can_accept = (state_q == ST_EMPTY) || out_ready;

  // Grant depends only on valids, prio and the output side, never on the
  // ready outputs themselves, so there is no combinational loop. Gating with
  // rst_n keeps both readies low for the whole reset period.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (rst_n && can_accept) begin
      if (r0_valid && r1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = prio_q;
      end else if (r0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (r1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  // A grant is only ever given to a valid requester, so a grant is an accept.
  assign r0_ready = gnt_vld && !gnt_id;
  assign r1_ready = gnt_vld &&  gnt_id;

  // Idle adder inputs are held at zero to keep the shared datapath quiet.
  assign add_a = !gnt_vld ? '0 : (gnt_id ? r1_a : r0_a);
  assign add_b = !gnt_vld ? '0 : (gnt_id ? r1_b : r0_b);

  // Next-state: accept loads a new result (also covering drain+accept in the
  // same cycle); a drain without accept only empties the slot, data holds.
  always_comb begin
    state_d = state_q;
    vect_d  = vect_q;
    src_d   = src_q;
    prio_d  = prio_q;
    if (gnt_vld) begin
      state_d = ST_FULL;
      vect_d  = add_sum;
      src_d   = gnt_id;
      prio_d  = ~gnt_id;   // the loser of this round wins the next tie
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order. All of them
  // are reset, including the result data, so a pending result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      vect_q  <= '0;
      src_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vect_q  <= vect_d;
      src_q   <= src_d;
      prio_q  <= prio_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_vect  = vect_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_vect_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vect_add_arbiter
//   Directed bench for vect_add_arbiter. A lane-wise adder stands in for the
//   shared vect_adder. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
`ifndef N_MAX
`define N_MAX 2
`endif

module tb_vect_add_arbiter;

  localparam int W  = 43;
  localparam int VW = `N_MAX * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [VW-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [VW-1:0] add_a, add_b, add_sum;
  logic          out_valid, out_ready, out_src;
  logic [VW-1:0] out_vect;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vect_add_arbiter #(.WIDTH(W), .FRAC(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vect  (out_vect),
    .out_src   (out_src)
  );

  // Stand-in for the shared vect_adder: per-lane add, wrapping modulo 2^W.
  for (genvar l = 0; l < `N_MAX; l++) begin : g_adder
    assign add_sum[l*W +: W] = add_a[l*W +: W] + add_b[l*W +: W];
  end

  // Vector with lane0/lane1 set and remaining lanes zero.
  function automatic logic [VW-1:0] mk(input logic [W-1:0] l0, input logic [W-1:0] l1);
    logic [VW-1:0] v;
    v = '0;
    v[0 +: W] = l0;
    v[W +: W] = l1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] held;

  initial begin
    // ---- reset state ----
    rst_n     = 1'b0;
    out_ready = 1'b1;
    r0_valid  = 1'b1;
    r1_valid  = 1'b1;
    r0_a = mk(43'd10,  43'd2);
    r0_b = mk(43'd20,  43'd3);
    r1_a = mk(43'd1000, 43'd100);
    r1_b = mk(43'd2000, 43'd200);
    #3;
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_out_vect",  out_vect, '0);
    check("rst_out_src",   VW'(out_src), VW'(0));
    check("rst_r0_ready",  VW'(r0_ready), VW'(0));
    check("rst_r1_ready",  VW'(r1_ready), VW'(0));
    tick();
    rst_n = 1'b1;

    // ---- contention: both valid, grants alternate r0,r1,r0,r1 ----
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_r0_ready", i), VW'(r0_ready), VW'((i % 2) == 0));
      check($sformatf("cont%0d_r1_ready", i), VW'(r1_ready), VW'((i % 2) == 1));
      tick();
      check($sformatf("cont%0d_out_valid", i), VW'(out_valid), VW'(1));
      check($sformatf("cont%0d_out_src", i),   VW'(out_src),   VW'(i % 2));
      check($sformatf("cont%0d_out_vect", i),  out_vect,
            ((i % 2) == 0) ? mk(43'd30, 43'd5) : mk(43'd3000, 43'd300));
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    // ---- single r0: 1.0 + 0.5 in lane0 ----
    r0_a = mk(43'h1_0000_0000, 43'd5);
    r0_b = mk(43'h0_8000_0000, 43'd7);
    r0_valid = 1'b1;
    #1;
    check("single_r0_ready", VW'(r0_ready), VW'(1));
    check("single_r1_ready", VW'(r1_ready), VW'(0));
    check("single_add_a", add_a, mk(43'h1_0000_0000, 43'd5));
    check("single_add_b", add_b, mk(43'h0_8000_0000, 43'd7));
    tick();
    r0_valid = 1'b0;
    check("single_out_valid", VW'(out_valid), VW'(1));
    check("single_out_vect",  out_vect, mk(43'h1_8000_0000, 43'd12));
    check("single_out_src",   VW'(out_src), VW'(0));

    // ---- idle: no valid, drain ----
    #1;
    check("idle_add_a", add_a, '0);
    check("idle_add_b", add_b, '0);
    check("idle_r0_ready", VW'(r0_ready), VW'(0));
    tick();
    check("idle_out_valid", VW'(out_valid), VW'(0));
    check("idle_out_vect_hold", out_vect, mk(43'h1_8000_0000, 43'd12));
    // prio was left at r1 by the r0 grant and must survive the idle cycle
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1;
    check("idle_prio_r1_ready", VW'(r1_ready), VW'(1));
    check("idle_prio_r0_ready", VW'(r0_ready), VW'(0));

    // ---- backpressure ----
    tick();
    r1_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_first_src",  VW'(out_src), VW'(1));
    check("bp_first_vect", out_vect, mk(43'd3000, 43'd300));
    held = mk(43'd3000, 43'd300);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_r0_ready", i), VW'(r0_ready), VW'(0));
      check($sformatf("bp%0d_r1_ready", i), VW'(r1_ready), VW'(0));
      tick();
      check($sformatf("bp%0d_out_valid", i), VW'(out_valid), VW'(1));
      check($sformatf("bp%0d_out_vect", i),  out_vect, held);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_r0_ready", VW'(r0_ready), VW'(1));
    tick();
    r0_valid = 1'b0;
    check("bp_release_out_valid", VW'(out_valid), VW'(1));
    check("bp_release_out_src",   VW'(out_src), VW'(0));
    check("bp_release_out_vect",  out_vect, mk(43'h1_8000_0000, 43'd12));

    // ---- wrap: max positive + 1, all-ones + 1 ----
    r1_a = mk(43'h3FF_FFFF_FFFF, 43'h7FF_FFFF_FFFF);
    r1_b = mk(43'd1, 43'd1);
    r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    check("wrap_out_vect", out_vect, mk(43'h400_0000_0000, 43'd0));
    check("wrap_out_src",  VW'(out_src), VW'(1));

    // ---- reset mid-transfer with a result pending and prio at r1 ----
    r0_valid = 1'b1;
    tick();                  // r0 accepted, prio moves to r1
    check("pre_rst_out_src", VW'(out_src), VW'(0));
    out_ready = 1'b0;
    r1_valid  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", VW'(out_valid), VW'(0));
    check("arst_out_vect",  out_vect, '0);
    check("arst_out_src",   VW'(out_src), VW'(0));
    check("arst_r0_ready",  VW'(r0_ready), VW'(0));
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_r0_ready", VW'(r0_ready), VW'(1));
    check("post_rst_r1_ready", VW'(r1_ready), VW'(0));
    tick();
    check("post_rst_out_src",  VW'(out_src), VW'(0));
    check("post_rst_out_vect", out_vect, mk(43'h1_8000_0000, 43'd12));
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
